// File: rtl/randsack_regs_pkg.sv
// Shared constants and types for the randsack Wishbone register block:
// register offsets, STATUS/CTRL bit positions, default ID and responder states.
package randsack_regs_pkg;

  localparam logic [7:0] OFF_ID      = 8'h00;
  localparam logic [7:0] OFF_CTRL    = 8'h04;
  localparam logic [7:0] OFF_SCRATCH = 8'h08;
  localparam logic [7:0] OFF_STATUS  = 8'h0C;
  localparam logic [7:0] OFF_DATA    = 8'h10;

  localparam int STATUS_EMPTY     = 0;
  localparam int STATUS_MISSED    = 1;
  localparam int STATUS_UNDERFLOW = 2;
  localparam int STATUS_COUNT_LSB = 4;
  localparam int STATUS_COUNT_W   = 4;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [31:0] ID_DEFAULT = 32'h5241_4E44;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

endpackage

// File: rtl/randsack_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; read data is always the head entry.
// Pointers wrap naturally at the power-of-two boundary.
module randsack_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage carries no reset; an entry is only ever read after a push has written it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/randsack_wb_regs.sv
// Wishbone classic register responder for the randsack entropy FIFO.
// Build option RANDSACK_REGS_IRQ_EN adds CTRL[1] irq_en and a registered irq_o.
module randsack_wb_regs
  import randsack_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        rnd_valid_i,
  input  logic [31:0] rnd_data_i,
  output logic        rnd_ready_o,
  output logic        ctrl_en_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t      state;
  state_t      state_next;
  logic        hit;
  logic        access;
  logic        wr;
  logic        rd;
  logic [7:0]  offset;

  logic        enable;
  logic        irq_en;
  logic [31:0] scratch;
  logic        missed;
  logic        underflow;

  logic        push;
  logic        pop_req;
  logic        pop;
  logic [31:0] head;
  logic        full;
  logic        empty;
  logic [CW-1:0] count;

  logic [31:0] ctrl_word;
  logic [31:0] status_word;
  logic [31:0] rdata;

  assign offset = wbs_adr_i[7:0];
  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // An access is only taken from IDLE, so a strobe held through ACK is served every other cycle.
  assign access = (state == IDLE) & hit;
  assign wr     = access & wbs_we_i;
  assign rd     = access & ~wbs_we_i;

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (hit) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign wbs_ack_o = (state == ACK);

  assign rnd_ready_o = enable & ~full;
  assign push        = rnd_valid_i & rnd_ready_o;
  assign pop_req     = rd & (offset == OFF_DATA);
  assign pop         = pop_req & ~empty;
  assign ctrl_en_o   = enable;

  randsack_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (rnd_data_i),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable <= 1'b0;
    end else if (wr && offset == OFF_CTRL) begin
      enable <= wbs_dat_i[CTRL_ENABLE];
    end
  end

`ifdef RANDSACK_REGS_IRQ_EN
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr && offset == OFF_CTRL) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      irq_o <= irq_en & ~empty;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scratch <= '0;
    end else if (wr && offset == OFF_SCRATCH) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) scratch[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

  // Sticky flags: a set event in the same cycle as a W1C clear wins.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      missed    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      missed <= (missed & ~(wr && offset == OFF_STATUS && wbs_dat_i[STATUS_MISSED]))
              | (rnd_valid_i & enable & full);
      underflow <= (underflow & ~(wr && offset == OFF_STATUS && wbs_dat_i[STATUS_UNDERFLOW]))
                 | (pop_req & empty);
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_ENABLE] = enable;
    ctrl_word[CTRL_IRQ_EN] = irq_en;
  end

  always_comb begin
    status_word                                      = '0;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W]  = STATUS_COUNT_W'(count);
    status_word[STATUS_UNDERFLOW]                    = underflow;
    status_word[STATUS_MISSED]                       = missed;
    status_word[STATUS_EMPTY]                        = empty;
  end

  always_comb begin
    rdata = '0;
    unique case (offset)
      OFF_ID:      rdata = ID_VALUE;
      OFF_CTRL:    rdata = ctrl_word;
      OFF_SCRATCH: rdata = scratch;
      OFF_STATUS:  rdata = status_word;
      OFF_DATA:    rdata = empty ? '0 : head;
      default:     rdata = '0;
    endcase
  end

  // Read data is captured only on a read access, so it is zero whenever ack is low.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni)  wbs_dat_o <= '0;
    else if (rd)  wbs_dat_o <= rdata;
    else          wbs_dat_o <= '0;
  end

endmodule

// File: doc/randsack_wb_regs.md
# randsack_wb_regs

Wishbone classic responder for the randsack user project in the Caravel user area. Management-core firmware uses it to read an ID, exercise a scratch register, control the entropy source, and drain random words from a small FIFO. It answers the same firmware register read/write traffic that the directed reg-rw bench drives; results then appear on the checkbits GPIOs.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, block base; bits [31:8] are decoded.
- FIFO_DEPTH, 4, random-word FIFO entries; must be a power of two, at least 2.
- ID_VALUE, 32'h5241_4E44, value of the ID register.

Ports:
- wb_clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- rnd_valid_i  in  1  entropy word valid.
- rnd_data_i  in  32  entropy word.
- rnd_ready_o  out  1  FIFO accepts the word.
- ctrl_en_o  out  1  entropy source enable (CTRL[0]).
- irq_o  out  1  data-available interrupt.

## Operation
- Hit condition: cyc & stb & adr[31:8]==BASE_ADDR[31:8]. A miss is never acked.
- Register map (offset = adr[7:0]):
  - 0x00 ID: read-only, ID_VALUE.
  - 0x04 CTRL: read/write. [0] enable, [1] irq_en. Other bits read 0.
  - 0x08 SCRATCH: read/write. Each byte lane is written only when its sel bit is set.
  - 0x0C STATUS: [7:4] count, [2] underflow, [1] missed, [0] empty. Writing 1 to bit [2] or [1] clears that bit (W1C).
  - 0x10 DATA: read-only. A read pops the FIFO head.
  - Other offsets: read 0, writes ignored, still acked.
- CTRL, SCRATCH and STATUS ignore wbs_sel_i except where stated.
- Push: rnd_valid_i & rnd_ready_o, where rnd_ready_o = enable & !full.
- missed: set when rnd_valid_i & enable & full.
- DATA read when empty: returns 0, sets underflow, FIFO unchanged.
- Push and pop in the same cycle: count unchanged. If the FIFO is empty, the pop returns 0, sets underflow, and the push still lands.
- Clearing enable does not flush the FIFO.

## Timing
- Responder FSM: IDLE -> ACK on a hit while ack is low. ACK -> IDLE unconditionally.
  - wbs_ack_o is high for exactly 1 cycle, 1 cycle after the strobe: 1-cycle latency.
  - A strobe held through ACK is served again; minimum 2 cycles per access.
- wbs_dat_o is registered and valid only with ack. It is 0 whenever ack is low.
- Register writes, the FIFO pop and W1C clears take effect on the edge that raises ack.
- The FIFO count update and sticky-flag set are visible in STATUS on the next access.
- If a W1C clear and a new set event hit the same bit in the same cycle, the set wins.
- Reset (asynchronous, any time, including mid-access) returns every output to its reset value.
  - Reset values: wbs_ack_o=0, wbs_dat_o=0, rnd_ready_o=0, ctrl_en_o=0, irq_o=0, SCRATCH=0, FIFO empty, flags 0, FSM IDLE.
  - Any access in flight is dropped without an ack.

## Configuration
- RANDSACK_REGS_IRQ_EN defined:
  - irq_o = irq_en & !empty, registered, so it follows the FIFO state with 1-cycle lag.
  - CTRL[1] is read/write.
- RANDSACK_REGS_IRQ_EN undefined:
  - irq_o tied 0.
  - CTRL[1] is not implemented: reads 0, writes ignored.

## Structure
- Package randsack_regs_pkg holds:
  - the register offset localparams;
  - STATUS bit positions;
  - the default ID constant;
  - the FSM state typedef {IDLE, ACK}.
- Sub-module randsack_sync_fifo: parameterized depth and width, with push/pop/full/empty/count, and read data taken from the head. It does the FIFO storage and pointer wrap-around.

## Test plan
- Reset, then read 0x00 -> 32'h5241_4E44 with ack 1 cycle after the strobe. Read 0x0C -> 32'h1 (empty).
- Write SCRATCH 32'h5555_5555, then write 32'hAAAA_FEED with sel=4'b0011 -> read back 32'h5555_FEED.
- Enable, push 0x11, 0x22, 0x33 -> STATUS count=3. DATA reads return 0x11, 0x22, 0x33 in order, then empty=1.
- Enable, hold rnd_valid_i for 6 words with FIFO_DEPTH=4:
  - rnd_ready_o drops after 4 words and missed=1.
  - Write 0x2 to 0x0C -> missed=0.
  - Drain 4 words; the pointers have wrapped and order is preserved.
- DATA read on empty -> 0 and underflow=1. With a same-cycle push of 0x99, the next DATA read -> 0x99.
- Assert rst_ni low during ACK -> ack drops immediately and FIFO/SCRATCH are cleared. With RANDSACK_REGS_IRQ_EN defined, irq_o rises 1 cycle after the first push with irq_en=1.
